// File: rtl/mul8_pkg.sv
// Shared definitions for the sequential 8x8 multiplier arbiter:
// FSM state encoding, operand/product widths, step count and the
// partial-product alignment helper.
package mul8_pkg;

    localparam int OP_W     = 8;
    localparam int PROD_W   = 16;
    localparam int STEP_CNT = 4;
    localparam int STEP_W   = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Align a 4x4 partial product to its weight for the given step:
    // step 0 -> x1, steps 1/2 -> x16, step 3 -> x256.
    function automatic logic [PROD_W-1:0] shift_pp(input logic [7:0] pp,
                                                   input logic [STEP_W-1:0] step);
        logic [PROD_W-1:0] r;
        case (step)
            2'd0:    r = {8'd0, pp};
            2'd1,
            2'd2:    r = {4'd0, pp, 4'd0};
            default: r = {pp, 8'd0};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/four_bit_multiplier.sv
// Combinational 4x4 unsigned multiplier; the single shared datapath
// element that the sequencer time-multiplexes across four steps.
module four_bit_multiplier (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);

    // Operands are zero-extended to the product width before multiplying.
    assign p = {4'd0, a} * {4'd0, b};

endmodule

// File: rtl/mul8_seq_arbiter.sv
// Two-requester round-robin arbiter feeding a sequential 8x8 multiplier
// built from one shared 4x4 multiplier (four partial products per job).
// Optional feature macro: MUL8_ZERO_SKIP_EN -- when defined, a job whose
// latched operands contain a zero skips the partial-product steps and
// reports product 0 one cycle after the grant.
module mul8_seq_arbiter
    import mul8_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic [OP_W-1:0]   req0_a,
    input  logic [OP_W-1:0]   req0_b,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [OP_W-1:0]   req1_a,
    input  logic [OP_W-1:0]   req1_b,
    output logic              req1_ready,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [PROD_W-1:0] res_product,
    output logic              res_id,
    output logic              busy
);

    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEP_CNT - 1);

    state_t              state_q, state_d;
    logic                ptr_q, ptr_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [PROD_W-1:0]   acc_q, acc_d;
    logic [OP_W-1:0]     op_a_q, op_a_d;
    logic [OP_W-1:0]     op_b_q, op_b_d;
    logic                id_q, id_d;
    logic [PROD_W-1:0]   res_product_q, res_product_d;
    logic                res_id_q, res_id_d;
    logic                res_valid_q, res_valid_d;
    logic                busy_q, busy_d;

    logic                gnt0, gnt1;
    logic [3:0]          mul_a, mul_b;
    logic [7:0]          mul_p;
    logic [PROD_W-1:0]   acc_sum;

    // Round-robin pick: the pointer breaks ties, a lone requester always wins.
    assign gnt0 = req0_valid & (~req1_valid | ~ptr_q);
    assign gnt1 = req1_valid & (~req0_valid |  ptr_q);

    assign req0_ready  = (state_q == ST_IDLE) & gnt0;
    assign req1_ready  = (state_q == ST_IDLE) & gnt1;
    assign res_valid   = res_valid_q;
    assign res_product = res_product_q;
    assign res_id      = res_id_q;
    assign busy        = busy_q;

    // Step bit 0 selects the high nibble of a, step bit 1 the high nibble of b.
    assign mul_a = step_q[0] ? op_a_q[7:4] : op_a_q[3:0];
    assign mul_b = step_q[1] ? op_b_q[7:4] : op_b_q[3:0];

    four_bit_multiplier u_mul (
        .a (mul_a),
        .b (mul_b),
        .p (mul_p)
    );

    assign acc_sum = acc_q + shift_pp(mul_p, step_q);

    // Next-state and registered-output logic for the IDLE/CALC/DONE sequencer.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        step_d        = step_q;
        acc_d         = acc_q;
        op_a_d        = op_a_q;
        op_b_d        = op_b_q;
        id_d          = id_q;
        res_product_d = res_product_q;
        res_id_d      = res_id_q;
        res_valid_d   = res_valid_q;
        busy_d        = busy_q;

        case (state_q)
            ST_IDLE: begin
                if (gnt0 | gnt1) begin
                    op_a_d  = gnt1 ? req1_a : req0_a;
                    op_b_d  = gnt1 ? req1_b : req0_b;
                    id_d    = gnt1;
                    ptr_d   = ~gnt1;
                    acc_d   = '0;
                    step_d  = '0;
                    state_d = ST_CALC;
                    busy_d  = 1'b1;
                end
            end
            ST_CALC: begin
`ifdef MUL8_ZERO_SKIP_EN
                if ((step_q == '0) && ((op_a_q == '0) || (op_b_q == '0))) begin
                    acc_d         = '0;
                    res_product_d = '0;
                    res_id_d      = id_q;
                    res_valid_d   = 1'b1;
                    state_d       = ST_DONE;
                end else begin
`else
                begin
`endif
                    acc_d  = acc_sum;
                    step_d = step_q + 2'd1;
                    if (step_q == LAST_STEP) begin
                        res_product_d = acc_sum;
                        res_id_d      = id_q;
                        res_valid_d   = 1'b1;
                        state_d       = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    step_d      = '0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                res_valid_d = 1'b0;
                busy_d      = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any job in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            ptr_q         <= 1'b0;
            step_q        <= '0;
            acc_q         <= '0;
            op_a_q        <= '0;
            op_b_q        <= '0;
            id_q          <= 1'b0;
            res_product_q <= '0;
            res_id_q      <= 1'b0;
            res_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            step_q        <= step_d;
            acc_q         <= acc_d;
            op_a_q        <= op_a_d;
            op_b_q        <= op_b_d;
            id_q          <= id_d;
            res_product_q <= res_product_d;
            res_id_q      <= res_id_d;
            res_valid_q   <= res_valid_d;
            busy_q        <= busy_d;
        end
    end

endmodule
